// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register controller: frame layout, register map, FSM states.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;
    localparam logic [CNT_W-1:0] CNT_SAT = 5'd17;

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam int NUM_OUT = 5;
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input; reset loads the line's idle level.
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) sr <= {DEPTH{RST_VAL}};
        else     sr <= {sr[DEPTH-2:0], d};
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave writing a small PWM register file; 16-bit frames {rw, addr[6:0], data[7:0]}.
// Optional readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);
    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);
    localparam logic [6:0] NUM_OUT_A  = 7'(NUM_OUT);

    logic sclk_s, copi_s, ncs_s;
    logic sclk_q, ncs_q;
    logic [SYNC_STAGES:0] flush;
    logic armed;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst(rst), .d(copi), .q(copi_s));
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst(rst), .d(ncs),  .q(ncs_s));

    // Edges are only trusted once the synchronizers hold real pin samples and ncs
    // has been seen high, so a frame already running at reset release is skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 1'b0;
            ncs_q  <= 1'b1;
            flush  <= '0;
            armed  <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            ncs_q  <= ncs_s;
            flush  <= {flush[SYNC_STAGES-1:0], 1'b1};
            if (flush[SYNC_STAGES] && ncs_s) armed <= 1'b1;
        end
    end

    logic sclk_rise, ncs_fall, ncs_rise;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign ncs_fall  = armed & ncs_q & ~ncs_s;
    assign ncs_rise  = ncs_s & ~ncs_q;

    state_t state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [FRAME_BITS-1:0] frame;
    logic [6:0]            addr;
    logic                  start, shift_en, commit_en;

    assign addr = frame[ADDR_MSB:ADDR_LSB];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (ncs_fall) state_nx = ST_SHIFT;
            ST_SHIFT:  if (ncs_rise) state_nx = ST_COMMIT;
            ST_COMMIT: state_nx = ncs_fall ? ST_SHIFT : ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        start     = (state_nx == ST_SHIFT) && (state != ST_SHIFT);
        shift_en  = (state == ST_SHIFT) && sclk_rise;
        commit_en = (state == ST_COMMIT) && (cnt == 5'(FRAME_BITS)) && frame[RW_BIT]
                    && (addr < NUM_REGS_A) && (addr < NUM_OUT_A);
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt   <= '0;
            frame <= '0;
        end else if (shift_en) begin
            frame <= {frame[FRAME_BITS-2:0], copi_s};
            if (cnt != CNT_SAT) cnt <= cnt + 5'd1;
        end
    end

    logic [7:0] regs [NUM_OUT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) regs[i] <= '0;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= commit_en;
            if (commit_en) regs[addr[2:0]] <= frame[DATA_MSB:DATA_LSB];
        end
    end

    assign en_reg_out_7_0  = regs[3'(ADDR_EN_OUT_LO)];
    assign en_reg_out_15_8 = regs[3'(ADDR_EN_OUT_HI)];
    assign en_reg_pwm_7_0  = regs[3'(ADDR_EN_PWM_LO)];
    assign en_reg_pwm_15_8 = regs[3'(ADDR_EN_PWM_HI)];
    assign pwm_duty_cycle  = regs[3'(ADDR_PWM_DUTY)];

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_sr;

    assign sclk_fall = ~sclk_s & sclk_q;
    // At the 8th rise the header is the 7 bits already held plus the incoming bit.
    assign rd_addr = {frame[5:0], copi_s};
    assign rd_data = ((rd_addr < NUM_REGS_A) && (rd_addr < NUM_OUT_A)) ? regs[rd_addr[2:0]] : 8'h00;

    // The fall right after the load is skipped so the MSB is held through the 9th rise.
    always_ff @(posedge clk) begin
        if (rst || state != ST_SHIFT)            tx_sr <= '0;
        else if (shift_en && cnt == 5'd7)        tx_sr <= frame[6] ? 8'h00 : rd_data;
        else if (sclk_fall && cnt >= 5'd9)       tx_sr <= {tx_sr[6:0], 1'b0};
    end

    assign cipo = tx_sr[7];
`else
    assign cipo = 1'b0;
`endif
endmodule
